// File: rtl/cpu_pkg.sv
// Shared CPU constants and the MEM-stage arbiter state encoding.
package cpu_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC1 = 2'd1,
    ACC2 = 2'd2,
    DONE = 2'd3
  } arb_state_e;

endpackage : cpu_pkg

// File: rtl/dual_mem_arbiter_if.sv
// Single data-memory port shared by both issue lanes.
interface dual_mem_arbiter_if #(
  parameter int unsigned ADDR_W = cpu_pkg::ADDR_W,
  parameter int unsigned DATA_W = cpu_pkg::DATA_W
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ready;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ready, mem_rdata
  );
endinterface : dual_mem_arbiter_if

// File: rtl/dual_mem_arbiter_sat_counter.sv
// Saturating up-counter with increment enable and synchronous reset.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  // Holds at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != '1)) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule : sat_counter

// File: rtl/dual_mem_arbiter.sv
// Serializes the memory ops of a dual-issue bundle onto one data port,
// lane 1 before lane 2, stalling the front end until the bundle completes.
module dual_mem_arbiter
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_W = cpu_pkg::ADDR_W,
  parameter int unsigned DATA_W = cpu_pkg::DATA_W,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_memread1,
  input  logic                i_memwrite1,
  input  logic [ADDR_W-1:0]   i_addr1,
  input  logic [DATA_W-1:0]   i_wdata1,
  input  logic                i_memread2,
  input  logic                i_memwrite2,
  input  logic [ADDR_W-1:0]   i_addr2,
  input  logic [DATA_W-1:0]   i_wdata2,
  dual_mem_arbiter_if.master  mem,
  output logic                o_stall,
  output logic                o_done,
  output logic [DATA_W-1:0]   o_rdata1,
  output logic [DATA_W-1:0]   o_rdata2,
  output logic [CNT_W-1:0]    o_conflict_cnt
);

  arb_state_e        r_state;
  arb_state_e        w_next;
  logic              w_act1;
  logic              w_act2;
  logic              w_stall;
  logic              w_done;
  logic              w_req;
  logic              w_we;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;
  logic              w_cap1;
  logic              w_cap2;
  logic              w_cnt_inc;
  logic [DATA_W-1:0] r_rdata1;
  logic [DATA_W-1:0] r_rdata2;

  assign w_act1 = i_memread1 | i_memwrite1;
  assign w_act2 = i_memread2 | i_memwrite2;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and port decode; lane fields are read live since stall holds EX/MEM.
  always_comb begin
    w_next    = r_state;
    w_stall   = 1'b0;
    w_done    = 1'b0;
    w_req     = 1'b0;
    w_we      = 1'b0;
    w_addr    = '0;
    w_wdata   = '0;
    w_cap1    = 1'b0;
    w_cap2    = 1'b0;
    w_cnt_inc = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_act1 || w_act2) begin
          w_stall   = 1'b1;
          w_next    = w_act1 ? ACC1 : ACC2;
          w_cnt_inc = w_act1 & w_act2;
        end else begin
          w_done = 1'b1;
        end
      end
      ACC1: begin
        w_stall = 1'b1;
        w_req   = 1'b1;
        w_we    = i_memwrite1;
        w_addr  = i_addr1;
        w_wdata = i_wdata1;
        if (mem.mem_ready) begin
          w_cap1 = ~i_memwrite1;
          w_next = w_act2 ? ACC2 : DONE;
        end
      end
      ACC2: begin
        w_stall = 1'b1;
        w_req   = 1'b1;
        w_we    = i_memwrite2;
        w_addr  = i_addr2;
        w_wdata = i_wdata2;
        if (mem.mem_ready) begin
          w_cap2 = ~i_memwrite2;
          w_next = DONE;
        end
      end
      DONE: begin
        w_done = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Reset outranks a same-cycle mem_ready, so an abandoned load never lands.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rdata1 <= '0;
      r_rdata2 <= '0;
    end else begin
      if (w_cap1) r_rdata1 <= mem.mem_rdata;
      if (w_cap2) r_rdata2 <= mem.mem_rdata;
    end
  end

  sat_counter #(
    .W (CNT_W)
  ) u_conflict_cnt (
    .clk   (clk),
    .reset (reset),
    .i_inc (w_cnt_inc),
    .o_cnt (o_conflict_cnt)
  );

  assign mem.mem_req   = w_req;
  assign mem.mem_we    = w_we;
  assign mem.mem_addr  = w_addr;
  assign mem.mem_wdata = w_wdata;
  assign o_stall       = w_stall;
  assign o_done        = w_done;
  assign o_rdata1      = r_rdata1;
  assign o_rdata2      = r_rdata2;

endmodule : dual_mem_arbiter

// File: tb/tb_dual_mem_arbiter.sv
// Directed bench for dual_mem_arbiter: bundle vector table plus reset and saturation sequences.
module tb_dual_mem_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  typedef struct {
    logic        rd1;
    logic        wr1;
    logic [31:0] a1;
    logic [31:0] wd1;
    logic        rd2;
    logic        wr2;
    logic [31:0] a2;
    logic [31:0] wd2;
    int          wait_n;
    int          exp_stall;
    int          exp_req;
    int          exp_acc;
    logic [31:0] exp_first_a;
    logic        exp_first_we;
    logic [31:0] exp_r1;
    logic [31:0] exp_r2;
    logic [31:0] exp_cnt;
  } vec_t;

  logic        clk;
  logic        reset;
  logic        rd1, wr1, rd2, wr2;
  logic [31:0] a1, wd1, a2, wd2;
  logic        ready;
  logic [31:0] rbus;
  logic        stall, done, stall4, done4;
  logic [31:0] r1, r2, r1_4, r2_4;
  logic [15:0] cnt;
  logic [3:0]  cnt4;
  logic [31:0] mem [16];

  int total;
  int bad;

  dual_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) mif  ();
  dual_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) mif4 ();

  assign mif.mem_ready  = ready;
  assign mif.mem_rdata  = rbus;
  assign mif4.mem_ready = ready;
  assign mif4.mem_rdata = rbus;

  dual_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .i_memread1(rd1), .i_memwrite1(wr1), .i_addr1(a1), .i_wdata1(wd1),
    .i_memread2(rd2), .i_memwrite2(wr2), .i_addr2(a2), .i_wdata2(wd2),
    .mem(mif.master),
    .o_stall(stall), .o_done(done), .o_rdata1(r1), .o_rdata2(r2),
    .o_conflict_cnt(cnt)
  );

  dual_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(4)) dut4 (
    .clk(clk), .reset(reset),
    .i_memread1(rd1), .i_memwrite1(wr1), .i_addr1(a1), .i_wdata1(wd1),
    .i_memread2(rd2), .i_memwrite2(wr2), .i_addr2(a2), .i_wdata2(wd2),
    .mem(mif4.master),
    .o_stall(stall4), .o_done(done4), .o_rdata1(r1_4), .o_rdata2(r2_4),
    .o_conflict_cnt(cnt4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_lanes(input vec_t v);
    rd1 = v.rd1; wr1 = v.wr1; a1 = v.a1; wd1 = v.wd1;
    rd2 = v.rd2; wr2 = v.wr2; a2 = v.a2; wd2 = v.wd2;
  endtask

  // Runs one bundle from IDLE through its done cycle, acting as a wait-state memory.
  task automatic run_bundle(input vec_t v, input string tag);
    int          held, n_stall, n_req, n_acc, zero_bad;
    logic        got_first, finished, s_req, s_we;
    logic [31:0] first_a, s_addr, s_wdata;
    logic        first_we;
    held = 0; n_stall = 0; n_req = 0; n_acc = 0; zero_bad = 0;
    got_first = 1'b0; finished = 1'b0; first_a = '0; first_we = 1'b0;
    set_lanes(v);
    for (int c = 0; c < 40 && !finished; c++) begin
      @(negedge clk);
      s_req = mif.mem_req; s_we = mif.mem_we; s_addr = mif.mem_addr; s_wdata = mif.mem_wdata;
      if (s_req) begin
        ready = (held == v.wait_n);
        rbus  = mem[s_addr[5:2]];
        n_req++;
        if (!got_first) begin
          got_first = 1'b1; first_a = s_addr; first_we = s_we;
        end
        if (ready) begin n_acc++; held = 0; end
        else held++;
      end else begin
        ready = 1'b0;
        rbus  = '0;
        if (s_we !== 1'b0 || s_addr !== '0 || s_wdata !== '0) zero_bad++;
      end
      if (stall) n_stall++;
      if (done) begin
        finished = 1'b1;
        chk({tag, " stall_in_done"}, 32'(stall), 32'd0);
        chk({tag, " rdata1"}, r1, v.exp_r1);
        chk({tag, " rdata2"}, r2, v.exp_r2);
        chk({tag, " conflict_cnt"}, 32'(cnt), v.exp_cnt);
      end
      @(posedge clk);
      if (s_req && ready && s_we) mem[s_addr[5:2]] = s_wdata;
      #1;
    end
    ready = 1'b0;
    rbus  = '0;
    chk({tag, " done_seen"}, 32'(finished), 32'd1);
    chk({tag, " stall_cycles"}, 32'(n_stall), 32'(v.exp_stall));
    chk({tag, " req_cycles"}, 32'(n_req), 32'(v.exp_req));
    chk({tag, " accesses"}, 32'(n_acc), 32'(v.exp_acc));
    chk({tag, " first_addr"}, first_a, v.exp_first_a);
    chk({tag, " first_we"}, 32'(first_we), 32'(v.exp_first_we));
    chk({tag, " idle_bus_zero"}, 32'(zero_bad), 32'd0);
  endtask

  vec_t vecs [8];
  vec_t dv;

  initial begin
    total = 0; bad = 0;
    reset = 1'b1; ready = 1'b0; rbus = '0;
    rd1 = 0; wr1 = 0; a1 = '0; wd1 = '0; rd2 = 0; wr2 = 0; a2 = '0; wd2 = '0;
    for (int i = 0; i < 16; i++) mem[i] = '0;
    mem[4] = 32'hDEADBEEF;

    //           rd1 wr1 a1     wd1      rd2 wr2 a2     wd2     w st rq ac first  we r1           r2           cnt
    vecs[0] = '{1, 0, 32'h10, 32'h0,    0, 0, 32'h0,  32'h0,  0, 2, 1, 1, 32'h10, 0, 32'hDEADBEEF, 32'h0,        32'd0};
    vecs[1] = '{0, 1, 32'h20, 32'h1234, 1, 0, 32'h20, 32'h0,  0, 3, 2, 2, 32'h20, 1, 32'hDEADBEEF, 32'h1234,     32'd1};
    vecs[2] = '{0, 0, 32'h0,  32'h0,    1, 0, 32'h10, 32'h0,  3, 5, 4, 1, 32'h10, 0, 32'hDEADBEEF, 32'hDEADBEEF, 32'd1};
    vecs[3] = '{1, 1, 32'h30, 32'h55,   1, 0, 32'h30, 32'h0,  1, 5, 4, 2, 32'h30, 1, 32'hDEADBEEF, 32'h55,       32'd2};
    vecs[4] = '{1, 0, 32'h20, 32'h0,    0, 1, 32'h20, 32'h99, 0, 3, 2, 2, 32'h20, 0, 32'h1234,     32'h55,       32'd3};
    vecs[5] = '{0, 0, 32'h0,  32'h0,    0, 0, 32'h0,  32'h0,  0, 0, 0, 0, 32'h0,  0, 32'h1234,     32'h55,       32'd3};
    vecs[6] = '{0, 0, 32'h0,  32'h0,    0, 1, 32'h04, 32'hAB, 0, 2, 1, 1, 32'h04, 1, 32'h1234,     32'h55,       32'd3};
    vecs[7] = '{1, 0, 32'h04, 32'h0,    0, 0, 32'h0,  32'h0,  2, 4, 3, 1, 32'h04, 0, 32'hAB,       32'h55,       32'd3};

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst mem_req", 32'(mif.mem_req), 32'd0);
    chk("rst mem_addr", mif.mem_addr, 32'd0);
    chk("rst stall", 32'(stall), 32'd0);
    chk("rst done", 32'(done), 32'd1);
    chk("rst rdata1", r1, 32'd0);
    chk("rst rdata2", r2, 32'd0);
    chk("rst cnt", 32'(cnt), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Quiet bundles flow through without stalling or requesting memory.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("idle stall", 32'(stall), 32'd0);
      chk("idle done", 32'(done), 32'd1);
      chk("idle mem_req", 32'(mif.mem_req), 32'd0);
      @(posedge clk); #1;
    end

    for (int i = 0; i < 8; i++) run_bundle(vecs[i], $sformatf("vec%0d", i));

    // Reset lands in ACC2 while mem_ready is high.
    dv = '{1, 0, 32'h10, 32'h0, 1, 0, 32'h20, 32'h0, 0, 0, 0, 0, 32'h0, 0, 32'h0, 32'h0, 32'd0};
    set_lanes(dv);
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rstacc cnt_before", 32'(cnt), 32'd4);
    chk("rstacc acc1_addr", mif.mem_addr, 32'h10);
    ready = 1'b1; rbus = mem[4];
    @(posedge clk); #1;
    @(negedge clk);
    chk("rstacc acc2_req", 32'(mif.mem_req), 32'd1);
    chk("rstacc acc2_addr", mif.mem_addr, 32'h20);
    ready = 1'b1; rbus = 32'hBAD0BAD0; reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; ready = 1'b0; rbus = '0;
    @(negedge clk);
    chk("rstacc mem_req", 32'(mif.mem_req), 32'd0);
    chk("rstacc stall_idle", 32'(stall), 32'd1);
    chk("rstacc rdata1", r1, 32'd0);
    chk("rstacc rdata2", r2, 32'd0);
    chk("rstacc cnt", 32'(cnt), 32'd0);
    chk("rstacc cnt4", 32'(cnt4), 32'd0);
    rd1 = 0; rd2 = 0;
    @(posedge clk); #1;

    // Seventeen dual bundles: 4-bit counter pins at 15, wide one keeps counting.
    for (int i = 0; i < 17; i++) begin
      dv = '{1, 0, 32'h10, 32'h0, 1, 0, 32'h20, 32'h0, 0, 3, 2, 2, 32'h10, 0,
             32'hDEADBEEF, 32'h99, 32'(i + 1)};
      run_bundle(dv, $sformatf("sat%0d", i));
      if (i == 14) chk("sat cnt4_at15", 32'(cnt4), 32'd15);
    end
    chk("sat cnt4_final", 32'(cnt4), 32'd15);
    chk("sat cnt_final", 32'(cnt), 32'd17);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_dual_mem_arbiter
